// File: rtl/vga_pixel_if.sv
// -----------------------------------------------------------------------------
// vga_pixel_if
// Bundle between the VGA raster/pixel output stage and its neighbours: the
// raster coordinates fanned out to the object generators, the RGB332 pixel
// returned by the object priority mux, and the expanded pixel/sync to the DAC.
//
//   RGBIn        [7:0]  RGB332 from object mux: [7:5]=R, [4:2]=G, [1:0]=B
//   pixelX       [10:0] current horizontal count
//   pixelY       [10:0] current vertical count
//   startOfFrame        1-cycle pulse at (0,0)
//   red/green/blue [7:0] expanded colour to DAC
//   hSync, vSync        active-low syncs
//   blankN              1 = active video
//
// Modports:
//   master - the raster/pixel output block (owns timing, consumes RGBIn)
//   slave  - the surrounding system (object mux + DAC side)
// -----------------------------------------------------------------------------
interface vga_pixel_if;
  logic [7:0]  RGBIn;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        hSync;
  logic        vSync;
  logic        blankN;

  modport master (
    input  RGBIn,
    output pixelX, pixelY, startOfFrame,
    output red, green, blue, hSync, vSync, blankN
  );

  modport slave (
    output RGBIn,
    input  pixelX, pixelY, startOfFrame,
    input  red, green, blue, hSync, vSync, blankN
  );
endinterface

// File: rtl/vga_pixel_output.sv
// -----------------------------------------------------------------------------
// vga_pixel_output
// Generates 640x480@60 VGA raster timing, publishes pixelX/pixelY to the
// object generators, takes back the mux's registered RGB332 pixel, delays the
// decoded sync/blank by the mux latency, expands RGB332 to 8:8:8 and forces
// black outside the active area. Every DAC-side output is registered and sits
// MUX_LATENCY+1 clocks behind the pixelX/pixelY that produced it.
//
// Ports:
//   clk     pixel clock, single domain
//   resetN  asynchronous active-low reset
//   vga     vga_pixel_if.master (RGBIn in; counters, sync, blank, RGB out)
// -----------------------------------------------------------------------------
module vga_pixel_output #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int MUX_LATENCY = 1   // 1..4
) (
  input  logic        clk,
  input  logic        resetN,
  vga_pixel_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] X_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
  } timing_t;

  localparam timing_t TIMING_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  // run_q is low for the first edge after reset release: that edge holds the
  // counters at (0,0) and raises startOfFrame, so the first real pixel cycle
  // is (0,0) with the pulse, exactly like every later frame start.
  logic        run_q;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        sof_q, sof_d;

  timing_t     raw;
  timing_t     pipe_q [MUX_LATENCY];
  timing_t     tap;

  logic [2:0]  r_in, g_in;
  logic [1:0]  b_in;
  logic [7:0]  red_q, red_d;
  logic [7:0]  green_q, green_d;
  logic [7:0]  blue_q, blue_d;
  logic        hs_q, vs_q, blank_q;

  assign r_in = vga.RGBIn[7:5];
  assign g_in = vga.RGBIn[4:2];
  assign b_in = vga.RGBIn[1:0];

  // Raster counters.
  // NOTE: every variable written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (run_q) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 11'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end
    sof_d = (x_d == '0) && (y_d == '0);
  end

  // Raw timing decode of the current count; idle until the raster is running
  // so the hold cycle after reset does not inject a phantom pixel.
  always_comb begin
    raw = TIMING_IDLE;
    if (run_q) begin
      raw.active = (x_q < X_ACT) && (y_q < Y_ACT);
      raw.hs_n   = !((x_q >= HS_START) && (x_q < HS_END));
      raw.vs_n   = !((y_q >= VS_START) && (y_q < VS_END));
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      run_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      sof_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      x_q   <= x_d;
      y_q   <= y_d;
      sof_q <= sof_d;
    end
  end

  // Delay line matching the object mux latency.
  // NOTE: the delay line is reset along with everything else; otherwise stale
  // sync/active bits from before the reset would reach the monitor afterwards.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < MUX_LATENCY; i++) pipe_q[i] <= TIMING_IDLE;
    end else begin
      pipe_q[0] <= raw;
      for (int i = 1; i < MUX_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tap = pipe_q[MUX_LATENCY-1];

  // RGB332 -> 888 by bit replication so full scale maps to 8'hFF; black
  // whenever the delayed pixel lies outside the active area.
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (tap.active) begin
      red_d   = {r_in, r_in, r_in[2:1]};
      green_d = {g_in, g_in, g_in[2:1]};
      blue_d  = {b_in, b_in, b_in, b_in};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hs_q    <= tap.hs_n;
      vs_q    <= tap.vs_n;
      blank_q <= tap.active;
    end
  end

  assign vga.pixelX       = x_q;
  assign vga.pixelY       = y_q;
  assign vga.startOfFrame = sof_q;
  assign vga.red          = red_q;
  assign vga.green        = green_q;
  assign vga.blue         = blue_q;
  assign vga.hSync        = hs_q;
  assign vga.vSync        = vs_q;
  assign vga.blankN       = blank_q;

endmodule

// File: tb/tb_vga_pixel_output.sv
// -----------------------------------------------------------------------------
// tb_vga_pixel_output
// Two instances (MUX_LATENCY 1 and 3) share clock and reset. Horizontal timing
// is the real 640/16/96/48; the vertical totals are shrunk to a 13-line frame
// so several whole frames fit in a short run. A driver pushes the expected
// outputs of each cycle into a queue; a monitor on the falling edge pops and
// compares, and also measures pulse widths and frame period on DUT A.
// -----------------------------------------------------------------------------
module tb_vga_pixel_output;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 6,   VF = 2,  VS = 2,  VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 800
  localparam int VT = VA + VF + VS + VB;   // 13
  localparam int FRAME = HT * VT;          // 10400
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        sof;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hs;
    logic        vs;
    logic        blank;
  } obs_t;

  typedef struct {
    int   k;
    obs_t a;
    obs_t b;
  } exp_t;

  localparam obs_t RESET_OBS = '{x: 11'd0, y: 11'd0, sof: 1'b0, r: 8'h00,
                                 g: 8'h00, b: 8'h00, hs: 1'b1, vs: 1'b1,
                                 blank: 1'b0};

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  always #20 clk = ~clk;

  vga_pixel_if if_a ();
  vga_pixel_if if_b ();

  vga_pixel_output #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .MUX_LATENCY(LAT_A)
  ) dut_a (
    .clk(clk), .resetN(resetN), .vga(if_a)
  );

  vga_pixel_output #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .MUX_LATENCY(LAT_B)
  ) dut_b (
    .clk(clk), .resetN(resetN), .vga(if_b)
  );

  // Hand-computed RGB332 -> 888 vectors.
  logic [7:0]  vec_in  [5] = '{8'hE0, 8'h1C, 8'h03, 8'h92, 8'h6D};
  logic [23:0] vec_exp [5] = '{24'hFF0000, 24'h00FF00, 24'h0000FF,
                               24'h9292AA, 24'h6D6D55};

  int   errors = 0;
  int   checks = 0;
  bit   phase_b = 1'b0;     // second phase: frame 1 onwards drives 8'hFF
  exp_t sb_q [$];
  exp_t mon_e;

  int hs_run, vs_run, bl_run, last_sof;

  task automatic check(input string name, input int k,
                       input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%h expected=%h", name, k, got, exp);
    end
  endtask

  function automatic obs_t obs_a();
    return '{x: if_a.pixelX, y: if_a.pixelY, sof: if_a.startOfFrame,
             r: if_a.red, g: if_a.green, b: if_a.blue,
             hs: if_a.hSync, vs: if_a.vSync, blank: if_a.blankN};
  endfunction

  function automatic obs_t obs_b();
    return '{x: if_b.pixelX, y: if_b.pixelY, sof: if_b.startOfFrame,
             r: if_b.red, g: if_b.green, b: if_b.blue,
             hs: if_b.hSync, vs: if_b.vSync, blank: if_b.blankN};
  endfunction

  // Pixel n (counted from the first cycle after reset) carries this RGB332.
  function automatic logic [7:0] in_byte(input int n);
    if (phase_b && n >= FRAME) return 8'hFF;
    return vec_in[(n % HT) % 5];
  endfunction

  function automatic logic [23:0] exp_rgb(input int n);
    if (phase_b && n >= FRAME) return 24'hFFFFFF;
    return vec_exp[(n % HT) % 5];
  endfunction

  // Expected outputs in cycle k: counters show pixel k, the DAC side shows
  // pixel k-lat-1 (idle values before the first pixel arrives).
  function automatic obs_t model(input int k, input int lat);
    obs_t o;
    int   n, xn, yn;
    logic act;
    o.x   = 11'(k % HT);
    o.y   = 11'((k / HT) % VT);
    o.sof = (o.x == 11'd0) && (o.y == 11'd0);
    n = k - lat - 1;
    if (n < 0) begin
      {o.r, o.g, o.b} = 24'h0;
      o.hs    = 1'b1;
      o.vs    = 1'b1;
      o.blank = 1'b0;
    end else begin
      xn  = n % HT;
      yn  = (n / HT) % VT;
      act = (xn < HA) && (yn < VA);
      o.hs    = !((xn >= HA + HF) && (xn < HA + HF + HS));
      o.vs    = !((yn >= VA + VF) && (yn < VA + VF + VS));
      {o.r, o.g, o.b} = act ? exp_rgb(n) : 24'h0;
      o.blank = act;
    end
    return o;
  endfunction

  // Driver: cycle k starts at the posedge; RGBIn for pixel n is presented in
  // cycle n+lat, as a registered mux with that latency would.
  task automatic run_phase(input int ncyc);
    exp_t e;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      if_a.RGBIn = (k >= LAT_A) ? in_byte(k - LAT_A) : 8'h00;
      if_b.RGBIn = (k >= LAT_B) ? in_byte(k - LAT_B) : 8'h00;
      e.k = k;
      e.a = model(k, LAT_A);
      e.b = model(k, LAT_B);
      sb_q.push_back(e);
    end
  endtask

  // Monitor: compares every scoreboard entry and measures run lengths on A.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("dut_a_outputs", mon_e.k, 64'(obs_a()), 64'(mon_e.a));
      check("dut_b_outputs", mon_e.k, 64'(obs_b()), 64'(mon_e.b));
      if (mon_e.k == 0) begin
        hs_run = 0; vs_run = 0; bl_run = 0; last_sof = -1;
      end
      if (!if_a.hSync) hs_run++;
      else if (hs_run > 0) begin
        check("hsync_low_width", mon_e.k, 64'(hs_run), 64'(HS));
        hs_run = 0;
      end
      if (!if_a.vSync) vs_run++;
      else if (vs_run > 0) begin
        check("vsync_low_width", mon_e.k, 64'(vs_run), 64'(VS * HT));
        vs_run = 0;
      end
      if (if_a.blankN) bl_run++;
      else if (bl_run > 0) begin
        check("active_width", mon_e.k, 64'(bl_run), 64'(HA));
        bl_run = 0;
      end
      if (if_a.startOfFrame) begin
        if (last_sof >= 0)
          check("sof_period", mon_e.k, 64'(mon_e.k - last_sof), 64'(FRAME));
        last_sof = mon_e.k;
      end
    end
  end

  initial begin
    if_a.RGBIn = 8'h00;
    if_b.RGBIn = 8'h00;

    // Phase A: run into line 0, then assert reset mid-line at pixelX=300.
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    run_phase(301);
    @(negedge clk);             // monitor checks cycle 300 here
    #2;
    resetN = 1'b0;
    #1;
    check("reset_async_a", -1, 64'(obs_a()), 64'(RESET_OBS));
    check("reset_async_b", -1, 64'(obs_b()), 64'(RESET_OBS));
    repeat (3) @(posedge clk);
    #1;
    check("reset_held_a", -1, 64'(obs_a()), 64'(RESET_OBS));
    check("reset_held_b", -1, 64'(obs_b()), 64'(RESET_OBS));

    // Phase B: two full frames plus the wrap into a third.
    @(negedge clk);
    resetN  = 1'b1;
    phase_b = 1'b1;
    run_phase(2 * FRAME + 50);
    @(negedge clk);
    #1;
    check("scoreboard_drained", -1, 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
